// File: rtl/load_store_unit_if.sv
// rtl/load_store_unit_if.sv - MEM-stage and data_memory signal bundle for load_store_unit
interface load_store_unit_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32
);
    logic                  MemReadM;
    logic                  MemWriteM;
    logic [2:0]            funct3M;
    logic [ADDR_WIDTH-1:0] ALUResultM;
    logic [DATA_WIDTH-1:0] WriteDataM;
    logic [DATA_WIDTH-1:0] ReadDataM;
    logic                  StallM;
    logic                  MisalignM;
    logic [ADDR_WIDTH-1:0] BadAddr;
    logic                  DM_WE;
    logic [ADDR_WIDTH-1:0] DM_A;
    logic [DATA_WIDTH-1:0] DM_WD;
    logic [DATA_WIDTH-1:0] DM_RD;

    // master: pipeline MEM stage plus data_memory; slave: the load/store unit
    modport master (
        output MemReadM, MemWriteM, funct3M, ALUResultM, WriteDataM, DM_RD,
        input  ReadDataM, StallM, MisalignM, BadAddr, DM_WE, DM_A, DM_WD
    );
    modport slave (
        input  MemReadM, MemWriteM, funct3M, ALUResultM, WriteDataM, DM_RD,
        output ReadDataM, StallM, MisalignM, BadAddr, DM_WE, DM_A, DM_WD
    );
endinterface

// File: rtl/load_store_unit.sv
// rtl/load_store_unit.sv - RV32I load/store unit with sub-word RMW stores; LSU_MISALIGN_TRAP_EN enables misalign trapping
module load_store_unit #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32
) (
    input logic              clk,
    input logic              reset,
    load_store_unit_if.slave bus
);
    typedef enum logic {IDLE, RMW_WR} state_t;

    state_t                state, state_n;
    logic [ADDR_WIDTH-1:0] addr_q, word_addr;
    logic [DATA_WIDTH-1:0] merge_q, merged, load_val;
    logic [1:0]            size;
    logic                  load_ok, store_ok, misalign, start_rmw;
    logic [7:0]            rd_byte;
    logic [15:0]           rd_half;

    assign size      = bus.funct3M[1:0];
    assign word_addr = {bus.ALUResultM[ADDR_WIDTH-1:2], 2'b00};
    assign rd_half   = bus.ALUResultM[1] ? bus.DM_RD[31:16] : bus.DM_RD[15:0];

    always_comb begin
        load_ok  = 1'b0;
        store_ok = 1'b0;
        case (bus.funct3M)
            3'b000, 3'b001, 3'b010: begin
                load_ok  = 1'b1;
                store_ok = 1'b1;
            end
            3'b100, 3'b101: load_ok = 1'b1;
            default: ;
        endcase
    end

`ifdef LSU_MISALIGN_TRAP_EN
    logic [ADDR_WIDTH-1:0] bad_q;

    assign misalign = (state == IDLE) && !reset &&
                      (bus.MemWriteM ? store_ok : (bus.MemReadM && load_ok)) &&
                      ((size == 2'b01 && bus.ALUResultM[0]) ||
                       (size == 2'b10 && bus.ALUResultM[1:0] != 2'b00));

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            bad_q <= '0;
        else if (misalign)
            bad_q <= bus.ALUResultM;
    end
    assign bus.BadAddr = bad_q;
`else
    assign misalign    = 1'b0;
    assign bus.BadAddr = '0;
`endif

    always_comb begin
        rd_byte = bus.DM_RD[7:0];
        case (bus.ALUResultM[1:0])
            2'b01:   rd_byte = bus.DM_RD[15:8];
            2'b10:   rd_byte = bus.DM_RD[23:16];
            2'b11:   rd_byte = bus.DM_RD[31:24];
            default: rd_byte = bus.DM_RD[7:0];
        endcase
    end

    always_comb begin
        case (bus.funct3M)
            3'b000:  load_val = {{24{rd_byte[7]}}, rd_byte};
            3'b001:  load_val = {{16{rd_half[15]}}, rd_half};
            3'b010:  load_val = bus.DM_RD;
            3'b100:  load_val = {24'b0, rd_byte};
            3'b101:  load_val = {16'b0, rd_half};
            default: load_val = '0;
        endcase
    end

    // Current memory word with the store lane overwritten, captured for the RMW write cycle
    always_comb begin
        merged = bus.DM_RD;
        if (size == 2'b00) begin
            case (bus.ALUResultM[1:0])
                2'b00: merged[7:0]   = bus.WriteDataM[7:0];
                2'b01: merged[15:8]  = bus.WriteDataM[7:0];
                2'b10: merged[23:16] = bus.WriteDataM[7:0];
                2'b11: merged[31:24] = bus.WriteDataM[7:0];
                default: ;
            endcase
        end else if (bus.ALUResultM[1]) begin
            merged[31:16] = bus.WriteDataM[15:0];
        end else begin
            merged[15:0] = bus.WriteDataM[15:0];
        end
    end

    always_comb begin
        state_n       = state;
        start_rmw     = 1'b0;
        bus.DM_WE     = 1'b0;
        bus.DM_A      = word_addr;
        bus.DM_WD     = bus.WriteDataM;
        bus.StallM    = 1'b0;
        bus.ReadDataM = '0;
        bus.MisalignM = misalign;
        if (!reset) begin
            case (state)
                IDLE: begin
                    if (bus.MemWriteM) begin
                        if (store_ok && !misalign) begin
                            if (size == 2'b10) begin
                                bus.DM_WE = 1'b1;
                            end else begin
                                bus.StallM = 1'b1;
                                start_rmw  = 1'b1;
                                state_n    = RMW_WR;
                            end
                        end
                    end else if (bus.MemReadM && load_ok && !misalign) begin
                        bus.ReadDataM = load_val;
                    end
                end
                RMW_WR: begin
                    bus.DM_WE = 1'b1;
                    bus.DM_A  = addr_q;
                    bus.DM_WD = merge_q;
                    state_n   = IDLE;
                end
                default: state_n = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            addr_q  <= '0;
            merge_q <= '0;
        end else begin
            state <= state_n;
            if (start_rmw) begin
                addr_q  <= word_addr;
                merge_q <= merged;
            end
        end
    end
endmodule
